mem_access_40: RTL and testbench
================================

# mem_access_40

Memory-access stage of the Nios II pipeline, directly downstream of the execute stage. Takes the execute stage's opcode, ALU result, store data and register fields. Performs LDW/STW through a req/ack data-memory handshake, stalling upstream while an access is outstanding. Registers the writeback result for the writeback stage.

## Interface
- MEM_TIMEOUT, 15: max cycles in ACCESS without `mem_ack_40` before the access is aborted (legal 1..255).
- clk_40  in  1  clock; all state updates on rising edge.
- rst_40  in  1  reset; asynchronous, active-low.
- in_valid_40  in  1  execute-stage outputs valid this cycle.
- opcode_40  in  6  opcode from execute.
- alu_out_40  in  32  ALU result / effective address.
- alu_src_40  in  32  store data (register B value).
- dest_reg_40  in  6  R-type destination register.
- targ_reg_40  in  6  I-type target register.
- stall_40  out  1  upstream must hold its outputs.
- mem_req_40  out  1  data-memory request.
- mem_we_40  out  1  1 = write (STW), 0 = read (LDW).
- mem_addr_40  out  32  word-aligned byte address.
- mem_wdata_40  out  32  store data.
- mem_rdata_40  in  32  load data; valid when `mem_ack_40` = 1.
- mem_ack_40  in  1  memory completion, single-cycle pulse.
- wb_valid_40  out  1  one-cycle pulse per retired instruction.
- wb_en_40  out  1  register write enable; qualified by `wb_valid_40`.
- wb_reg_40  out  6  writeback register index.
- wb_data_40  out  32  writeback data.
- opcode_out_40  out  6  opcode of the retired instruction.
- misalign_40  out  1  pulse: LDW/STW address[1:0] != 0.
- bus_err_40  out  1  sticky: a memory access timed out.

## Operation
- Opcodes:
  - ADD 110001, MUL 100111, ADDI 000100, SUBI 011111, LDW 010111, STW 010101, CALL 000000.
  - BR 000110, BEQ 100110, BNE 011110, BLT 010110, JMP 111010, NOPE 111111.
- Writeback register and data:
  - ADD, MUL: `dest_reg_40`, data = `alu_out_40`.
  - ADDI, SUBI: `targ_reg_40`, data = `alu_out_40`.
  - LDW: `targ_reg_40`, data = `mem_rdata_40`.
  - CALL: register 31, data = `alu_out_40`.
  - All other opcodes, including unknown: `wb_en_40` = 0.
- `wb_en_40` is forced to 0 whenever `wb_reg_40` = 0, since r0 is hard-wired.
- FSM states: IDLE, ACCESS.
- IDLE, `in_valid_40` = 0: no action, `wb_valid_40` = 0 next cycle.
- IDLE, non-memory opcode: writeback outputs are registered, `wb_valid_40` = 1 next cycle, state stays IDLE.
- IDLE, LDW/STW with `alu_out_40[1:0]` != 0:
  - No memory request is issued.
  - Next cycle: `wb_valid_40` = 1, `wb_en_40` = 0, `misalign_40` = 1.
- IDLE, LDW/STW aligned:
  - Latch address, store data, write flag, writeback register and opcode.
  - Clear the timeout counter and go to ACCESS.
- ACCESS:
  - `mem_req_40` = 1; `mem_addr_40`, `mem_we_40` and `mem_wdata_40` are held stable.
  - `mem_ack_40` sampled 1: retire the instruction and return to IDLE. LDW sets `wb_en_40` per the rules above; STW sets `wb_en_40` = 0.
  - No ack: the counter increments. When the counter reaches MEM_TIMEOUT, `mem_req_40` drops, `wb_valid_40` = 1 with `wb_en_40` = 0, `bus_err_40` is set, and the state returns to IDLE.
- `stall_40` = 1 exactly while the state is ACCESS (decoded combinationally from the state register). While stalled, the stage inputs are ignored.
- `mem_ack_40` received in IDLE is ignored.
- Outside active requests, `mem_req_40`, `mem_we_40`, `mem_addr_40` and `mem_wdata_40` are 0.

## Timing
- Reset (`rst_40` low) takes effect immediately and asynchronously:
  - State returns to IDLE.
  - Every output goes to 0, including `bus_err_40` and `stall_40`.
  - An in-flight access is abandoned: `mem_req_40` drops at once and no writeback is produced.
- Non-memory instruction: accepted at edge E0, `wb_*` valid for the cycle after E0 (latency 1, throughput 1/cycle).
- Aligned LDW/STW:
  - Accepted at E0; `mem_req_40` = 1 from E0.
  - Ack sampled at edge Ek (k ≥ 1): `wb_*` valid after Ek and the state is IDLE.
  - The next instruction is accepted at Ek+1 at the earliest.
  - Minimum latency is 2 cycles.
- Timeout: abort occurs at the edge where the ACCESS cycle count equals MEM_TIMEOUT. An ack arriving on that same edge wins: the access completes normally and no error is flagged.
- `wb_valid_40` and `misalign_40` are single-cycle pulses; `wb_reg_40`, `wb_data_40` and `opcode_out_40` hold their last value otherwise.

## Test plan
- **Reset values:** reset, then ADD with `alu_out_40` = 0x0000_0007 and `dest_reg_40` = 5. Required: one cycle later `wb_valid_40` = 1, `wb_en_40` = 1, `wb_reg_40` = 5, `wb_data_40` = 7, `stall_40` = 0.
- **Load:** LDW with address 0x100, `targ_reg_40` = 3, ack two cycles after the request with `mem_rdata_40` = 0xDEADBEEF. Required: `stall_40` high for 2 cycles, `mem_we_40` = 0, then writeback of 0xDEADBEEF to r3.
- **Store:** STW with address 0x204 and data 0x1234 → `mem_req_40` = 1, `mem_we_40` = 1, `mem_addr_40` = 0x204, `mem_wdata_40` = 0x1234. Required: on ack, `wb_valid_40` = 1, `wb_en_40` = 0.
- **Misaligned:** LDW with address 0x102 → no `mem_req_40`. Required: `misalign_40` and `wb_valid_40` pulse, `wb_en_40` = 0.
- **Timeout and reset mid-access:**
  - With no ack, after 15 ACCESS cycles `bus_err_40` = 1 (sticky), `stall_40` = 0 and the state is IDLE.
  - Drop `rst_40` during ACCESS: `mem_req_40` = 0 immediately and no `wb_valid_40` follows.
- **r0, CALL, branches:** ADDI to `targ_reg_40` = 0 → `wb_en_40` = 0. CALL with `alu_out_40` = 0x40 → r31 = 0x40. BEQ → `wb_valid_40` = 1, `wb_en_40` = 0.

Source files
------------

// File: rtl/mem_access_40.sv
// Nios II memory-access stage: retires ALU ops in 1 cycle; LDW/STW go through a req/ack data-memory handshake.
// Upstream is stalled (inputs ignored) for the whole ACCESS phase; an access with no ack is aborted after MEM_TIMEOUT cycles.
module mem_access_40 #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk_40,
    input  logic        rst_40,
    input  logic        in_valid_40,
    input  logic [5:0]  opcode_40,
    input  logic [31:0] alu_out_40,
    input  logic [31:0] alu_src_40,
    input  logic [5:0]  dest_reg_40,
    input  logic [5:0]  targ_reg_40,
    output logic        stall_40,
    output logic        mem_req_40,
    output logic        mem_we_40,
    output logic [31:0] mem_addr_40,
    output logic [31:0] mem_wdata_40,
    input  logic [31:0] mem_rdata_40,
    input  logic        mem_ack_40,
    output logic        wb_valid_40,
    output logic        wb_en_40,
    output logic [5:0]  wb_reg_40,
    output logic [31:0] wb_data_40,
    output logic [5:0]  opcode_out_40,
    output logic        misalign_40,
    output logic        bus_err_40
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    localparam logic [5:0] OP_ADD  = 6'b110001;
    localparam logic [5:0] OP_MUL  = 6'b100111;
    localparam logic [5:0] OP_ADDI = 6'b000100;
    localparam logic [5:0] OP_SUBI = 6'b011111;
    localparam logic [5:0] OP_LDW  = 6'b010111;
    localparam logic [5:0] OP_STW  = 6'b010101;
    localparam logic [5:0] OP_CALL = 6'b000000;

    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [5:0]  lreg_q, lreg_d;
    logic [5:0]  lop_q, lop_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_en_q, wb_en_d;
    logic [5:0]  wb_reg_q, wb_reg_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [5:0]  opc_q, opc_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic [5:0]  dec_reg;
    logic        dec_wr;
    logic        is_mem;
    logic        is_misal;
    logic        in_access;

    always_comb begin
        dec_reg = 6'd0;
        dec_wr  = 1'b0;
        case (opcode_40)
            OP_ADD, OP_MUL: begin
                dec_reg = dest_reg_40;
                dec_wr  = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_LDW: begin
                dec_reg = targ_reg_40;
                dec_wr  = 1'b1;
            end
            OP_CALL: begin
                dec_reg = 6'd31;
                dec_wr  = 1'b1;
            end
            OP_STW: begin
                dec_reg = targ_reg_40;
                dec_wr  = 1'b0;
            end
            default: begin
                dec_reg = 6'd0;
                dec_wr  = 1'b0;
            end
        endcase
    end

    assign is_mem    = (opcode_40 == OP_LDW) || (opcode_40 == OP_STW);
    assign is_misal  = (alu_out_40[1:0] != 2'b00);
    assign in_access = (state_q == S_ACCESS);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        lreg_d     = lreg_q;
        lop_d      = lop_q;
        wb_valid_d = 1'b0;
        wb_en_d    = wb_en_q;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        opc_d      = opc_q;
        misalign_d = 1'b0;
        bus_err_d  = bus_err_q;

        if (state_q == S_IDLE) begin
            if (in_valid_40) begin
                if (is_mem && is_misal) begin
                    wb_valid_d = 1'b1;
                    wb_en_d    = 1'b0;
                    wb_reg_d   = dec_reg;
                    wb_data_d  = alu_out_40;
                    opc_d      = opcode_40;
                    misalign_d = 1'b1;
                end else if (is_mem) begin
                    addr_d  = alu_out_40;
                    wdata_d = alu_src_40;
                    we_d    = (opcode_40 == OP_STW);
                    lreg_d  = dec_reg;
                    lop_d   = opcode_40;
                    cnt_d   = 8'd0;
                    state_d = S_ACCESS;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_en_d    = dec_wr && (dec_reg != 6'd0);
                    wb_reg_d   = dec_reg;
                    wb_data_d  = alu_out_40;
                    opc_d      = opcode_40;
                end
            end
        end else begin
            // An ack on the timeout edge takes priority over the abort.
            if (mem_ack_40) begin
                wb_valid_d = 1'b1;
                wb_reg_d   = lreg_q;
                opc_d      = lop_q;
                state_d    = S_IDLE;
                if (we_q) begin
                    wb_en_d = 1'b0;
                end else begin
                    wb_en_d   = (lreg_q != 6'd0);
                    wb_data_d = mem_rdata_40;
                end
            end else if (cnt_q == CNT_LAST) begin
                wb_valid_d = 1'b1;
                wb_en_d    = 1'b0;
                wb_reg_d   = lreg_q;
                opc_d      = lop_q;
                bus_err_d  = 1'b1;
                state_d    = S_IDLE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_40 or negedge rst_40) begin
        if (!rst_40) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            lreg_q     <= 6'd0;
            lop_q      <= 6'd0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_reg_q   <= 6'd0;
            wb_data_q  <= 32'd0;
            opc_q      <= 6'd0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            lreg_q     <= lreg_d;
            lop_q      <= lop_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
            opc_q      <= opc_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Bus outputs are gated by the state so they read zero outside a live request.
    assign stall_40      = in_access;
    assign mem_req_40    = in_access;
    assign mem_we_40     = in_access & we_q;
    assign mem_addr_40   = in_access ? addr_q : 32'd0;
    assign mem_wdata_40  = in_access ? wdata_q : 32'd0;

    assign wb_valid_40   = wb_valid_q;
    assign wb_en_40      = wb_en_q;
    assign wb_reg_40     = wb_reg_q;
    assign wb_data_40    = wb_data_q;
    assign opcode_out_40 = opc_q;
    assign misalign_40   = misalign_q;
    assign bus_err_40    = bus_err_q;

endmodule

// File: tb/tb_mem_access_40.sv
// Directed self-checking bench for mem_access_40.
module tb_mem_access_40;

    localparam logic [5:0] OP_ADD  = 6'b110001;
    localparam logic [5:0] OP_ADDI = 6'b000100;
    localparam logic [5:0] OP_LDW  = 6'b010111;
    localparam logic [5:0] OP_STW  = 6'b010101;
    localparam logic [5:0] OP_CALL = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b100110;

    logic        clk_40 = 1'b0;
    logic        rst_40;
    logic        in_valid_40;
    logic [5:0]  opcode_40;
    logic [31:0] alu_out_40;
    logic [31:0] alu_src_40;
    logic [5:0]  dest_reg_40;
    logic [5:0]  targ_reg_40;
    logic        stall_40;
    logic        mem_req_40;
    logic        mem_we_40;
    logic [31:0] mem_addr_40;
    logic [31:0] mem_wdata_40;
    logic [31:0] mem_rdata_40;
    logic        mem_ack_40;
    logic        wb_valid_40;
    logic        wb_en_40;
    logic [5:0]  wb_reg_40;
    logic [31:0] wb_data_40;
    logic [5:0]  opcode_out_40;
    logic        misalign_40;
    logic        bus_err_40;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_40 #(.MEM_TIMEOUT(15)) dut (
        .clk_40(clk_40), .rst_40(rst_40), .in_valid_40(in_valid_40),
        .opcode_40(opcode_40), .alu_out_40(alu_out_40), .alu_src_40(alu_src_40),
        .dest_reg_40(dest_reg_40), .targ_reg_40(targ_reg_40), .stall_40(stall_40),
        .mem_req_40(mem_req_40), .mem_we_40(mem_we_40), .mem_addr_40(mem_addr_40),
        .mem_wdata_40(mem_wdata_40), .mem_rdata_40(mem_rdata_40), .mem_ack_40(mem_ack_40),
        .wb_valid_40(wb_valid_40), .wb_en_40(wb_en_40), .wb_reg_40(wb_reg_40),
        .wb_data_40(wb_data_40), .opcode_out_40(opcode_out_40),
        .misalign_40(misalign_40), .bus_err_40(bus_err_40)
    );

    always #5 clk_40 = ~clk_40;

    // Advance one rising edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge clk_40);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] src,
                         input logic [5:0] dst, input logic [5:0] tgt);
        in_valid_40 = 1'b1;
        opcode_40   = op;
        alu_out_40  = alu;
        alu_src_40  = src;
        dest_reg_40 = dst;
        targ_reg_40 = tgt;
    endtask

    task automatic do_reset();
        rst_40 = 1'b0;
        step();
        step();
        rst_40 = 1'b1;
    endtask

    task automatic test_reset();
        in_valid_40 = 0; opcode_40 = 0; alu_out_40 = 0; alu_src_40 = 0;
        dest_reg_40 = 0; targ_reg_40 = 0; mem_rdata_40 = 0; mem_ack_40 = 0;
        rst_40 = 1'b0;
        #3;
        n_cmp++;
        if ({stall_40, mem_req_40, wb_valid_40, wb_en_40, misalign_40, bus_err_40} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got %b exp 000000",
                     {stall_40, mem_req_40, wb_valid_40, wb_en_40, misalign_40, bus_err_40});
        end
        n_cmp++;
        if ({mem_addr_40, wb_data_40} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_data got %h exp 0", {mem_addr_40, wb_data_40});
        end
        step();
        rst_40 = 1'b1;
        step();
        drive(OP_ADD, 32'h7, 32'h0, 6'd5, 6'd9);
        step();
        in_valid_40 = 1'b0;
        n_cmp++;
        if ({wb_valid_40, wb_en_40, wb_reg_40, wb_data_40, stall_40} !== {1'b1, 1'b1, 6'd5, 32'h7, 1'b0}) begin
            n_err++;
            $display("FAIL add_wb got v=%b en=%b r=%0d d=%h st=%b exp v=1 en=1 r=5 d=7 st=0",
                     wb_valid_40, wb_en_40, wb_reg_40, wb_data_40, stall_40);
        end
        step();
        n_cmp++;
        if (wb_valid_40 !== 1'b0) begin
            n_err++;
            $display("FAIL add_pulse got wb_valid=%b exp 0", wb_valid_40);
        end
    endtask

    task automatic test_load();
        int st_cycles = 0;
        drive(OP_LDW, 32'h100, 32'h0, 6'd0, 6'd3);
        step();
        in_valid_40 = 1'b0;
        n_cmp++;
        if ({mem_req_40, mem_we_40, mem_addr_40} !== {1'b1, 1'b0, 32'h100}) begin
            n_err++;
            $display("FAIL load_req got req=%b we=%b a=%h exp req=1 we=0 a=100",
                     mem_req_40, mem_we_40, mem_addr_40);
        end
        if (stall_40) st_cycles++;
        step();
        if (stall_40) st_cycles++;
        n_cmp++;
        if (wb_valid_40 !== 1'b0) begin
            n_err++;
            $display("FAIL load_early got wb_valid=%b exp 0", wb_valid_40);
        end
        mem_ack_40 = 1'b1;
        mem_rdata_40 = 32'hDEADBEEF;
        step();
        mem_ack_40 = 1'b0;
        mem_rdata_40 = 32'h0;
        if (stall_40) st_cycles++;
        n_cmp++;
        if (st_cycles != 2) begin
            n_err++;
            $display("FAIL load_stall got %0d cycles exp 2", st_cycles);
        end
        n_cmp++;
        if ({wb_valid_40, wb_en_40, wb_reg_40, wb_data_40, opcode_out_40, mem_req_40}
            !== {1'b1, 1'b1, 6'd3, 32'hDEADBEEF, OP_LDW, 1'b0}) begin
            n_err++;
            $display("FAIL load_wb got v=%b en=%b r=%0d d=%h op=%b req=%b exp v=1 en=1 r=3 d=deadbeef op=010111 req=0",
                     wb_valid_40, wb_en_40, wb_reg_40, wb_data_40, opcode_out_40, mem_req_40);
        end
    endtask

    task automatic test_store();
        drive(OP_STW, 32'h204, 32'h1234, 6'd0, 6'd7);
        step();
        in_valid_40 = 1'b0;
        n_cmp++;
        if ({mem_req_40, mem_we_40, mem_addr_40, mem_wdata_40} !== {1'b1, 1'b1, 32'h204, 32'h1234}) begin
            n_err++;
            $display("FAIL store_req got req=%b we=%b a=%h d=%h exp 1 1 204 1234",
                     mem_req_40, mem_we_40, mem_addr_40, mem_wdata_40);
        end
        mem_ack_40 = 1'b1;
        step();
        mem_ack_40 = 1'b0;
        n_cmp++;
        if ({wb_valid_40, wb_en_40, mem_req_40, mem_we_40, mem_addr_40, mem_wdata_40}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 64'd0}) begin
            n_err++;
            $display("FAIL store_wb got v=%b en=%b req=%b we=%b a=%h d=%h exp v=1 en=0 bus idle",
                     wb_valid_40, wb_en_40, mem_req_40, mem_we_40, mem_addr_40, mem_wdata_40);
        end
    endtask

    task automatic test_misaligned();
        drive(OP_LDW, 32'h102, 32'h0, 6'd0, 6'd3);
        step();
        in_valid_40 = 1'b0;
        n_cmp++;
        if ({mem_req_40, stall_40, misalign_40, wb_valid_40, wb_en_40} !== 5'b00110) begin
            n_err++;
            $display("FAIL misalign got req,st,mis,v,en=%b exp 00110",
                     {mem_req_40, stall_40, misalign_40, wb_valid_40, wb_en_40});
        end
        step();
        n_cmp++;
        if ({misalign_40, wb_valid_40, mem_req_40} !== 3'b000) begin
            n_err++;
            $display("FAIL misalign_pulse got mis,v,req=%b exp 000", {misalign_40, wb_valid_40, mem_req_40});
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        drive(OP_LDW, 32'h300, 32'h0, 6'd0, 6'd4);
        step();
        in_valid_40 = 1'b0;
        while (stall_40 && n < 40) begin
            step();
            n++;
        end
        n_cmp++;
        if (n != 15) begin
            n_err++;
            $display("FAIL timeout_len got %0d cycles exp 15", n);
        end
        n_cmp++;
        if ({bus_err_40, wb_valid_40, wb_en_40, mem_req_40, stall_40} !== 5'b11000) begin
            n_err++;
            $display("FAIL timeout_abort got err,v,en,req,st=%b exp 11000",
                     {bus_err_40, wb_valid_40, wb_en_40, mem_req_40, stall_40});
        end
        drive(OP_ADD, 32'h1, 32'h0, 6'd2, 6'd0);
        step();
        in_valid_40 = 1'b0;
        n_cmp++;
        if ({bus_err_40, wb_valid_40, wb_en_40} !== 3'b111) begin
            n_err++;
            $display("FAIL timeout_sticky got err,v,en=%b exp 111", {bus_err_40, wb_valid_40, wb_en_40});
        end
    endtask

    task automatic test_reset_mid();
        int vcount = 0;
        drive(OP_LDW, 32'h400, 32'h0, 6'd0, 6'd6);
        step();
        in_valid_40 = 1'b0;
        #2;
        rst_40 = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req_40, stall_40, bus_err_40} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid got req,st,err=%b exp 000", {mem_req_40, stall_40, bus_err_40});
        end
        step();
        rst_40 = 1'b1;
        mem_ack_40 = 1'b1;
        mem_rdata_40 = 32'hAAAA5555;
        step();
        mem_ack_40 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (wb_valid_40) vcount++;
            step();
        end
        n_cmp++;
        if (vcount != 0 || stall_40 !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_nowb got %0d writebacks stall=%b exp 0 0", vcount, stall_40);
        end
    endtask

    task automatic test_ack_wins();
        drive(OP_LDW, 32'h500, 32'h0, 6'd0, 6'd8);
        step();
        in_valid_40 = 1'b0;
        for (int i = 0; i < 14; i++) step();
        n_cmp++;
        if ({stall_40, wb_valid_40} !== 2'b10) begin
            n_err++;
            $display("FAIL ack_edge_pre got st,v=%b exp 10", {stall_40, wb_valid_40});
        end
        mem_ack_40 = 1'b1;
        mem_rdata_40 = 32'h0BADF00D;
        step();
        mem_ack_40 = 1'b0;
        n_cmp++;
        if ({wb_valid_40, wb_en_40, wb_reg_40, wb_data_40, bus_err_40, stall_40}
            !== {1'b1, 1'b1, 6'd8, 32'h0BADF00D, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL ack_wins got v=%b en=%b r=%0d d=%h err=%b st=%b exp 1 1 8 0badf00d 0 0",
                     wb_valid_40, wb_en_40, wb_reg_40, wb_data_40, bus_err_40, stall_40);
        end
    endtask

    task automatic test_back_to_back();
        drive(OP_ADDI, 32'h55, 32'h0, 6'd1, 6'd0);
        step();
        n_cmp++;
        if ({wb_valid_40, wb_en_40} !== 2'b10) begin
            n_err++;
            $display("FAIL addi_r0 got v,en=%b exp 10", {wb_valid_40, wb_en_40});
        end
        drive(OP_CALL, 32'h40, 32'h0, 6'd1, 6'd2);
        step();
        n_cmp++;
        if ({wb_valid_40, wb_en_40, wb_reg_40, wb_data_40} !== {1'b1, 1'b1, 6'd31, 32'h40}) begin
            n_err++;
            $display("FAIL call got v=%b en=%b r=%0d d=%h exp 1 1 31 40",
                     wb_valid_40, wb_en_40, wb_reg_40, wb_data_40);
        end
        drive(OP_BEQ, 32'h80, 32'h0, 6'd4, 6'd5);
        step();
        in_valid_40 = 1'b0;
        n_cmp++;
        if ({wb_valid_40, wb_en_40, opcode_out_40} !== {1'b1, 1'b0, OP_BEQ}) begin
            n_err++;
            $display("FAIL beq got v=%b en=%b op=%b exp 1 0 100110", wb_valid_40, wb_en_40, opcode_out_40);
        end
        mem_ack_40 = 1'b1;
        step();
        mem_ack_40 = 1'b0;
        n_cmp++;
        if ({wb_valid_40, stall_40, wb_data_40} !== {1'b0, 1'b0, 32'h80}) begin
            n_err++;
            $display("FAIL idle_ack got v=%b st=%b d=%h exp 0 0 80", wb_valid_40, stall_40, wb_data_40);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        do_reset();
        test_ack_wins();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
